// File: rtl/seg7_scan_driver_if.sv
// Display-driver bus: user-side value/decimal-point load plus the
// scanned segment, decimal point and digit-enable outputs.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                busy;
  logic                frame_done;

  modport master (
    output value, dp_in, load,
    input  seg, dp, an, busy, frame_done
  );

  modport slave (
    input  value, dp_in, load,
    output seg, dp, an, busy, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a DIGITS-wide seven-segment display.
// Define SEG7_LZB_EN to blank leading zero digits.
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 50000,
  parameter int INVERT    = 1,
  parameter int AN_INVERT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_driver_if.slave    disp_io
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [CW-1:0]     CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF = (INVERT != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (INVERT != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_INVERT != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     pend_val_q, pend_val_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [VW-1:0]     disp_val_q, disp_val_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic              busy_q, busy_d;
  logic              fdone_q, fdone_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic              tick, commit;
  logic [3:0]        nib;
  logic              lit_dp, sel_blank;
  logic [DIGITS-1:0] onehot, blank;
  logic [6:0]        raw;
`ifdef SEG7_LZB_EN
  logic              zero_above;
`endif

  // Glyphs in active-low form (bit 6 = g ... bit 0 = a).
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    g = 7'h7F;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // The display register only moves at frame wrap, so a frame never mixes values.
  always_comb begin
    tick       = (cnt_q == CNT_MAX);
    commit     = tick && (idx_q == IDX_MAX);
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    busy_d     = busy_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    if (disp_io.load) begin
      pend_val_d = disp_io.value;
      pend_dp_d  = disp_io.dp_in;
      busy_d     = 1'b1;
    end
    if (commit) begin
      disp_val_d = disp_io.load ? disp_io.value : pend_val_q;
      disp_dp_d  = disp_io.load ? disp_io.dp_in : pend_dp_q;
      busy_d     = 1'b0;
    end
    fdone_d = commit;
  end

  always_comb begin
    nib       = 4'h0;
    lit_dp    = 1'b0;
    sel_blank = 1'b0;
    onehot    = '0;
    blank     = '0;
`ifdef SEG7_LZB_EN
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (disp_val_q[4*i +: 4] == 4'h0);
      blank[i]   = zero_above;
    end
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = disp_val_q[4*i +: 4];
        lit_dp    = disp_dp_q[i];
        sel_blank = blank[i];
        onehot[i] = 1'b1;
      end
    end
    raw  = sel_blank ? 7'h7F : glyph(nib);
    seg_d = (INVERT != 0) ? raw : ~raw;
    dp_d  = (INVERT != 0) ? ~lit_dp : lit_dp;
    an_d  = (AN_INVERT != 0) ? ~onehot : onehot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      busy_q     <= 1'b0;
      fdone_q    <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      an_q       <= AN_OFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      busy_q     <= busy_d;
      fdone_q    <= fdone_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign disp_io.seg        = seg_q;
  assign disp_io.dp         = dp_q;
  assign disp_io.an         = an_q;
  assign disp_io.busy       = busy_q;
  assign disp_io.frame_done = fdone_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: one active-low instance and one
// active-high instance, both 4 digits with a 4-cycle slot.
module tb_seg7_scan_driver;
  typedef logic [13:0] entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  entry_t sb[$];

  logic [6:0] gly [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_scan_driver_if #(.DIGITS(4)) lo_if ();
  seg7_scan_driver_if #(.DIGITS(4)) hi_if ();

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .INVERT(1), .AN_INVERT(1)) u_lo (
    .clk(clk), .rst(rst), .disp_io(lo_if)
  );
  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .INVERT(0), .AN_INVERT(0)) u_hi (
    .clk(clk), .rst(rst), .disp_io(hi_if)
  );

  always #5 clk = ~clk;

  // Expected active-low glyph of digit d for value v, after optional blanking.
  function automatic logic [6:0] exp_raw(input logic [15:0] v, input int d);
    int top;
    logic [3:0] n;
    top = 0;
    for (int k = 0; k < 4; k++) if (v[4*k +: 4] != 4'h0) top = k;
    n = v[4*d +: 4];
`ifdef SEG7_LZB_EN
    if (d > top) return 7'h7F;
`endif
    return gly[n];
  endfunction

  task automatic push_frame(input int sel, input logic [15:0] v, input logic [3:0] dpv);
    logic [3:0] oh;
    logic [6:0] r;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        oh = 4'b0001 << d;
        r  = exp_raw(v, d);
        if (sel == 0) sb.push_back({~oh, r, ~dpv[d], 1'b0, (d == 3 && c == 3)});
        else          sb.push_back({oh, ~r, dpv[d], 1'b0, (d == 3 && c == 3)});
      end
    end
  endtask

  task automatic wait_frame(input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((sel == 0 ? lo_if.frame_done : hi_if.frame_done) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_lo(input logic [15:0] v, input logic [3:0] dpv);
    lo_if.value = v;
    lo_if.dp_in = dpv;
    lo_if.load  = 1'b1;
    @(negedge clk);
    lo_if.load  = 1'b0;
  endtask

  task automatic test_reset();
    entry_t obs;
    load_lo(16'h7777, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    obs = {lo_if.an, lo_if.seg, lo_if.dp, lo_if.busy, lo_if.frame_done};
    checks++;
    if (obs !== {4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_lo got=%h exp=%h", obs, {4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0});
    end
    obs = {hi_if.an, hi_if.seg, hi_if.dp, hi_if.busy, hi_if.frame_done};
    checks++;
    if (obs !== 14'h0) begin
      errors++;
      $display("[TB] FAIL reset_hi got=%h exp=%h", obs, 14'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs = {lo_if.an, lo_if.seg, lo_if.dp, lo_if.busy, lo_if.frame_done};
    checks++;
    if (obs !== {4'b1110, 7'b1000000, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL first_edge got=%h exp=%h", obs, {4'b1110, 7'b1000000, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_scan();
    bit ok;
    entry_t exp, obs;
    load_lo(16'h1234, 4'b0000);
    checks++;
    if (lo_if.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_rise got=%b exp=1", lo_if.busy);
    end
    wait_frame(0, ok);
    checks++;
    if (!ok || lo_if.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL commit_1234 frame_seen=%0d busy=%b exp frame_seen=1 busy=0", ok, lo_if.busy);
    end
    push_frame(0, 16'h1234, 4'b0000);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp = sb.pop_front();
      obs = {lo_if.an, lo_if.seg, lo_if.dp, lo_if.busy, lo_if.frame_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL scan_1234 k=%0d got=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_tear_free();
    bit found;
    entry_t exp, obs;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (lo_if.an === 4'b1011) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL digit2_wait an=%b exp=1011", lo_if.an);
    end
    load_lo(16'hABCD, 4'b0000);
    obs = {lo_if.an, lo_if.seg, lo_if.dp, lo_if.busy, lo_if.frame_done};
    checks++;
    if (obs !== {4'b1011, gly[2], 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL tear_digit2 got=%h exp=%h", obs, {4'b1011, gly[2], 1'b1, 1'b1, 1'b0});
    end
    @(negedge clk);
    load_lo(16'h9E0C, 4'b0000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (lo_if.an === 4'b0111) begin
        checks++;
        if (lo_if.seg !== gly[1]) begin
          errors++;
          $display("[TB] FAIL tear_digit3 got=%b exp=%b", lo_if.seg, gly[1]);
        end
      end
      if (lo_if.frame_done === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL tear_commit frame_done=%b exp=1", lo_if.frame_done);
    end
    push_frame(0, 16'h9E0C, 4'b0000);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp = sb.pop_front();
      obs = {lo_if.an, lo_if.seg, lo_if.dp, lo_if.busy, lo_if.frame_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL scan_9E0C k=%0d got=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_commit_cycle_load();
    entry_t exp, obs;
    repeat (15) @(negedge clk);
    load_lo(16'hF00F, 4'b0000);
    checks++;
    if ({lo_if.busy, lo_if.frame_done} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL commit_load busy,fd got=%b exp=01", {lo_if.busy, lo_if.frame_done});
    end
    push_frame(0, 16'hF00F, 4'b0000);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp = sb.pop_front();
      obs = {lo_if.an, lo_if.seg, lo_if.dp, lo_if.busy, lo_if.frame_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL scan_F00F k=%0d got=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_leading_zero();
    bit ok;
    entry_t exp, obs;
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    logic [3:0]  dps  [2] = '{4'b0100, 4'b0000};
    for (int t = 0; t < 2; t++) begin
      load_lo(vals[t], dps[t]);
      wait_frame(0, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL lzb_commit t=%0d frame_seen=0 exp=1", t);
      end
      push_frame(0, vals[t], dps[t]);
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        exp = sb.pop_front();
        obs = {lo_if.an, lo_if.seg, lo_if.dp, lo_if.busy, lo_if.frame_done};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL scan_lzb v=%h k=%0d got=%h exp=%h", vals[t], k, obs, exp);
        end
      end
    end
  endtask

  task automatic test_active_high();
    bit ok;
    entry_t exp, obs;
    hi_if.value = 16'h8888;
    hi_if.dp_in = 4'b0001;
    hi_if.load  = 1'b1;
    @(negedge clk);
    hi_if.load  = 1'b0;
    wait_frame(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL hi_commit frame_seen=0 exp=1");
    end
    push_frame(1, 16'h8888, 4'b0001);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp = sb.pop_front();
      obs = {hi_if.an, hi_if.seg, hi_if.dp, hi_if.busy, hi_if.frame_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL scan_hi k=%0d got=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  initial begin
    lo_if.value = '0;
    lo_if.dp_in = '0;
    lo_if.load  = 1'b0;
    hi_if.value = '0;
    hi_if.dp_in = '0;
    hi_if.load  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    test_reset();
    test_scan();
    test_tear_free();
    test_commit_cycle_load();
    test_leading_zero();
    test_active_high();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
